// File: rtl/writeback_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile_pkg
// Purpose  : Shared constants and types for the writeback / register file
//            slice: data width, register count, index width, FSM state
//            encoding and the {rd, value} request record used both for the
//            skid entry and for the commit bus.
// Revision : 1.0 - initial release
// ============================================================================
package writeback_regfile_pkg;

    localparam int BIN_DIG    = 32;
    localparam int REG_NUM    = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [BIN_DIG-1:0]    value;
    } wb_req_t;

endpackage : writeback_regfile_pkg
`default_nettype wire

// File: rtl/writeback_regfile_gpr_file.sv
`default_nettype none
// ============================================================================
// Module   : gpr_file
// Purpose  : 32-entry general register file with one write port and two
//            combinational read ports. Index 0 is hard-wired to zero; a read
//            of the index being written this cycle returns the write data.
// Ports    : clk, rst_n (sync, active-low, clears every register)
//            i_we / i_wr        - write enable and {rd, value} (rd != 0)
//            i_rs1_addr/o_rs1_data, i_rs2_addr/o_rs2_data - read ports
// Revision : 1.0 - initial release
// ============================================================================
module gpr_file
    import writeback_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_we,
    input  wb_req_t               i_wr,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    output logic [BIN_DIG-1:0]    o_rs1_data,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    output logic [BIN_DIG-1:0]    o_rs2_data
);

    logic [BIN_DIG-1:0] r_regs [REG_NUM];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we) begin
            r_regs[i_wr.rd] <= i_wr.value;
        end
    end

    // The caller never asserts i_we for rd 0, so the bypass compare needs
    // no extra x0 qualification; the explicit zero check covers storage.
    always_comb begin
        o_rs1_data = r_regs[i_rs1_addr];
        if (i_rs1_addr == '0) begin
            o_rs1_data = '0;
        end else if (i_we && (i_rs1_addr == i_wr.rd)) begin
            o_rs1_data = i_wr.value;
        end
    end

    always_comb begin
        o_rs2_data = r_regs[i_rs2_addr];
        if (i_rs2_addr == '0) begin
            o_rs2_data = '0;
        end else if (i_we && (i_rs2_addr == i_wr.rd)) begin
            o_rs2_data = i_wr.value;
        end
    end

endmodule : gpr_file
`default_nettype wire

// File: rtl/writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : writeback_regfile
// Purpose  : Final pipeline stage. Arbitrates load (mem) and execute (ex)
//            result writes, defers the ex write by one cycle through a
//            single-entry skid buffer when both arrive together (the load is
//            older and wins), and commits one result per cycle into gpr_file.
// Ports    : CLK, RST_N (sync, active-low)
//            ex_valid/ex_rd/ex_value/ex_ready     - execute result handshake
//            mem_valid/mem_rd/mem_value/mem_ready - load result handshake
//            rs1_addr/rs1_data, rs2_addr/rs2_data - bypassed read ports
//            wb_valid/wb_rd/wb_value              - registered commit report
//            retire_cnt                           - non-x0 commit counter
// Config   : WB_RETIRE_COUNT_EN - when defined, retire_cnt is a wrapping
//            32-bit counter; otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module writeback_regfile
    import writeback_regfile_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [BIN_DIG-1:0]    ex_value,
    output logic                  ex_ready,
    input  logic                  mem_valid,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic [BIN_DIG-1:0]    mem_value,
    output logic                  mem_ready,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [BIN_DIG-1:0]    rs1_data,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [BIN_DIG-1:0]    rs2_data,
    output logic                  wb_valid,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [BIN_DIG-1:0]    wb_value,
    output logic [31:0]           retire_cnt
);

    wb_state_t             r_state;
    wb_req_t               r_skid;
    logic                  r_wb_valid;
    logic [REG_ADDR_W-1:0] r_wb_rd;
    logic [BIN_DIG-1:0]    r_wb_value;

    logic                  w_commit_valid;
    wb_req_t               w_commit;
    logic                  w_skid_load;
    logic                  w_we;

    // Commit selection: in IDLE the load has priority and a simultaneous ex
    // result is parked in the skid buffer; in HOLD the parked entry commits.
    always_comb begin
        w_commit_valid = 1'b0;
        w_commit       = '0;
        w_skid_load    = 1'b0;
        case (r_state)
            IDLE: begin
                if (mem_valid) begin
                    w_commit_valid = 1'b1;
                    w_commit.rd    = mem_rd;
                    w_commit.value = mem_value;
                    w_skid_load    = ex_valid;
                end else if (ex_valid) begin
                    w_commit_valid = 1'b1;
                    w_commit.rd    = ex_rd;
                    w_commit.value = ex_value;
                end
            end
            HOLD: begin
                w_commit_valid = 1'b1;
                w_commit       = r_skid;
            end
            default: begin
                w_commit_valid = 1'b0;
            end
        endcase
    end

    // x0 commits are dropped entirely: no write, no report, no count.
    assign w_we      = w_commit_valid && (w_commit.rd != '0);
    assign ex_ready  = (r_state == IDLE);
    assign mem_ready = (r_state == IDLE);

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state    <= IDLE;
            r_skid     <= '0;
            r_wb_valid <= 1'b0;
            r_wb_rd    <= '0;
            r_wb_value <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_skid_load) begin
                        r_state      <= HOLD;
                        r_skid.rd    <= ex_rd;
                        r_skid.value <= ex_value;
                    end
                end
                HOLD: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            r_wb_valid <= w_we;
            if (w_we) begin
                r_wb_rd    <= w_commit.rd;
                r_wb_value <= w_commit.value;
            end
        end
    end

    assign wb_valid = r_wb_valid;
    assign wb_rd    = r_wb_rd;
    assign wb_value = r_wb_value;

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_retire_cnt <= '0;
        end else if (w_we) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`else
    assign retire_cnt = '0;
`endif

    gpr_file u_gpr_file (
        .clk        (CLK),
        .rst_n      (RST_N),
        .i_we       (w_we),
        .i_wr       (w_commit),
        .i_rs1_addr (rs1_addr),
        .o_rs1_data (rs1_data),
        .i_rs2_addr (rs2_addr),
        .o_rs2_data (rs2_data)
    );

endmodule : writeback_regfile
`default_nettype wire

// File: tb/tb_writeback_regfile.sv
`default_nettype none
// ============================================================================
// Module   : tb_writeback_regfile
// Purpose  : Directed self-checking bench for writeback_regfile. Inputs are
//            changed 1 ns after a rising edge; outputs are checked after a
//            further 1 ns settle, well away from the next edge.
// Config   : WB_RETIRE_COUNT_EN selects the expected retire_cnt behaviour.
// Revision : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile;
    import writeback_regfile_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [BIN_DIG-1:0]    ex_value;
    logic                  ex_ready;
    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [BIN_DIG-1:0]    mem_value;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] rs1_addr;
    logic [BIN_DIG-1:0]    rs1_data;
    logic [REG_ADDR_W-1:0] rs2_addr;
    logic [BIN_DIG-1:0]    rs2_data;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [BIN_DIG-1:0]    wb_value;
    logic [31:0]           retire_cnt;

    int n_vec;
    int n_err;
    int exp_cnt;

    writeback_regfile dut (
        .CLK        (clk),
        .RST_N      (rst_n),
        .ex_valid   (ex_valid),
        .ex_rd      (ex_rd),
        .ex_value   (ex_value),
        .ex_ready   (ex_ready),
        .mem_valid  (mem_valid),
        .mem_rd     (mem_rd),
        .mem_value  (mem_value),
        .mem_ready  (mem_ready),
        .rs1_addr   (rs1_addr),
        .rs1_data   (rs1_data),
        .rs2_addr   (rs2_addr),
        .rs2_data   (rs2_data),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_value   (wb_value),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and leave 1 ns for registered outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_exp(input int c);
`ifdef WB_RETIRE_COUNT_EN
        return 32'(c);
`else
        return 32'd0;
`endif
    endfunction

    initial begin
        n_vec = 0; n_err = 0; exp_cnt = 0;
        rst_n = 1'b0;
        ex_valid = 1'b0; ex_rd = '0; ex_value = '0;
        mem_valid = 1'b0; mem_rd = '0; mem_value = '0;
        rs1_addr = '0; rs2_addr = '0;
        step();
        step();

        // Reset state
        rs1_addr = 5'd5;
        #1;
        chk("rst_rs1", rs1_data, 32'h0);
        chk("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
        chk("rst_mem_ready", {31'b0, mem_ready}, 32'd1);
        chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rst_retire", retire_cnt, 32'd0);
        rst_n = 1'b1;
        step();

        // Single ex write with bypass during the commit cycle
        ex_valid = 1'b1; ex_rd = 5'd3; ex_value = 32'hDEADBEEF; rs2_addr = 5'd3;
        #1;
        chk("ex_bypass_rs2", rs2_data, 32'hDEADBEEF);
        step();
        exp_cnt++;
        ex_valid = 1'b0;
        chk("ex_wb_valid", {31'b0, wb_valid}, 32'd1);
        chk("ex_wb_rd", {27'b0, wb_rd}, 32'd3);
        chk("ex_wb_value", wb_value, 32'hDEADBEEF);
        rs1_addr = 5'd3; rs2_addr = 5'd0;
        #1;
        chk("ex_reg3", rs1_data, 32'hDEADBEEF);
        chk("ex_retire", retire_cnt, cnt_exp(exp_cnt));

        // Simultaneous mem rd4 / ex rd7
        mem_valid = 1'b1; mem_rd = 5'd4; mem_value = 32'h11;
        ex_valid = 1'b1; ex_rd = 5'd7; ex_value = 32'h22;
        rs1_addr = 5'd4; rs2_addr = 5'd7;
        #1;
        chk("dual_rs1_mem_bypass", rs1_data, 32'h11);
        chk("dual_rs2_ex_hidden", rs2_data, 32'h0);
        step();
        exp_cnt++;
        chk("dual_hold_ex_ready", {31'b0, ex_ready}, 32'd0);
        chk("dual_hold_mem_ready", {31'b0, mem_ready}, 32'd0);
        chk("dual_wb_rd4", {27'b0, wb_rd}, 32'd4);
        chk("dual_wb_val4", wb_value, 32'h11);
        chk("dual_reg4", rs1_data, 32'h11);
        chk("dual_skid_bypass7", rs2_data, 32'h22);
        step();
        exp_cnt++;
        mem_valid = 1'b0; ex_valid = 1'b0;
        #1;
        chk("dual_idle_ready", {31'b0, ex_ready}, 32'd1);
        chk("dual_wb_rd7", {27'b0, wb_rd}, 32'd7);
        chk("dual_wb_val7", wb_value, 32'h22);
        chk("dual_reg7", rs2_data, 32'h22);
        chk("dual_retire", retire_cnt, cnt_exp(exp_cnt));

        // Same-rd conflict on rd9
        mem_valid = 1'b1; mem_rd = 5'd9; mem_value = 32'hAA;
        ex_valid = 1'b1; ex_rd = 5'd9; ex_value = 32'hBB;
        rs1_addr = 5'd9;
        #1;
        chk("same_rd_cycle0", rs1_data, 32'hAA);
        step();
        exp_cnt++;
        chk("same_rd_wb_aa", wb_value, 32'hAA);
        chk("same_rd_hold_bypass", rs1_data, 32'hBB);
        step();
        exp_cnt++;
        mem_valid = 1'b0; ex_valid = 1'b0;
        #1;
        chk("same_rd_final", rs1_data, 32'hBB);
        chk("same_rd_wb_bb", wb_value, 32'hBB);

        // x0 write is discarded
        ex_valid = 1'b1; ex_rd = 5'd0; ex_value = 32'hFFFFFFFF; rs1_addr = 5'd0;
        #1;
        chk("x0_read_during", rs1_data, 32'h0);
        step();
        ex_valid = 1'b0;
        #1;
        chk("x0_read_after", rs1_data, 32'h0);
        chk("x0_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("x0_retire", retire_cnt, cnt_exp(exp_cnt));

        // mem-only write
        mem_valid = 1'b1; mem_rd = 5'd10; mem_value = 32'h55; rs2_addr = 5'd10;
        #1;
        chk("mem_only_bypass", rs2_data, 32'h55);
        step();
        exp_cnt++;
        mem_valid = 1'b0;
        #1;
        chk("mem_only_wb_rd", {27'b0, wb_rd}, 32'd10);
        chk("mem_only_reg10", rs2_data, 32'h55);
        chk("mem_only_retire", retire_cnt, cnt_exp(exp_cnt));

        // Reset while in HOLD discards the skid entry
        mem_valid = 1'b1; mem_rd = 5'd12; mem_value = 32'h1;
        ex_valid = 1'b1; ex_rd = 5'd13; ex_value = 32'h2;
        step();
        chk("rhold_in_hold", {31'b0, ex_ready}, 32'd0);
        rst_n = 1'b0; mem_valid = 1'b0; ex_valid = 1'b0;
        step();
        rst_n = 1'b1;
        rs1_addr = 5'd13; rs2_addr = 5'd12;
        #1;
        chk("rhold_ready", {31'b0, mem_ready}, 32'd1);
        chk("rhold_reg13", rs1_data, 32'h0);
        chk("rhold_reg12", rs2_data, 32'h0);
        chk("rhold_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rhold_retire", retire_cnt, 32'd0);
        step();
        chk("rhold_post_wb_valid", {31'b0, wb_valid}, 32'd0);
        chk("rhold_post_reg13", rs1_data, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_writeback_regfile
`default_nettype wire

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
Final pipeline stage, directly downstream of the data-memory stage and of the execute stage. It accepts result writes from both, orders them, and commits them to the 32-entry general register file. It exposes two combinational read ports with write-through bypass, which decode and execute use as the current general register values.

Parameters:
BIN_DIG, 32, data/register width in bits
REG_NUM, 32, number of general registers
REG_ADDR_W, 5, register index width (log2 REG_NUM)

Ports:
CLK  input  1  clock, all state updates on rising edge
RST_N  input  1  reset, synchronous, active-low
ex_valid  input  1  execute-stage result available
ex_rd  input  REG_ADDR_W  execute destination register
ex_value  input  BIN_DIG  execute result
ex_ready  output  1  execute result accepted this cycle
mem_valid  input  1  load result available (driven from the memory stage's load_active)
mem_rd  input  REG_ADDR_W  load destination register
mem_value  input  BIN_DIG  load data, already sign/zero-extended
mem_ready  output  1  load result accepted this cycle
rs1_addr  input  REG_ADDR_W  read port 1 index
rs1_data  output  BIN_DIG  read port 1 data
rs2_addr  input  REG_ADDR_W  read port 2 index
rs2_data  output  BIN_DIG  read port 2 data
wb_valid  output  1  registered: a register commit occurred last cycle
wb_rd  output  REG_ADDR_W  registered: committed index
wb_value  output  BIN_DIG  registered: committed value
retire_cnt  output  32  commit counter (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, CLK. Reset is synchronous, active-low (RST_N).
- Reset values while RST_N=0 at a rising edge:
  - all registers 0
  - state IDLE, skid buffer empty
  - wb_valid/wb_rd/wb_value 0
  - retire_cnt 0
- Ready outputs are combinational from state. Reset mid-HOLD discards the skid entry without committing it.
- State machine, two states:
  - IDLE (skid buffer empty): ex_ready=1, mem_ready=1.
    - Only one of mem_valid/ex_valid set: commit it at the next edge, stay IDLE.
    - Both set: commit the mem write and capture ex_rd/ex_value into the skid buffer; go to HOLD.
  - HOLD: ex_ready=0, mem_ready=0.
    - Commit the skid entry at the next edge; go to IDLE.
    - Upstream holds its valid/data stable while ready=0.
- Priority and latency:
  - Load wins simultaneous arrival because it is the older instruction.
  - Commit latency is 1 edge, or 2 edges for a deferred ex write.
- Commit rules:
  - A commit writes regs[rd] <= value.
  - rd=0 commits are discarded: no register change, wb_valid=0, counter unchanged.
  - Otherwise, on the same edge: wb_valid=1, wb_rd=rd, wb_value=value.
- Reads: combinational.
  - Index 0 always reads 0.
  - If the index equals the rd being committed this cycle, return the in-flight value (write-through bypass). Only one commit happens per cycle, so no bypass conflict arises.
  - The skid entry is also bypassed while in HOLD. While in IDLE with both valid, only the mem commit is bypassed; the ex value becomes visible in HOLD.
- Same-rd conflict:
  - mem and ex targeting the same rd in one cycle: final value is ex_value after HOLD.
  - Reads during that IDLE cycle return mem_value.
- Arithmetic: none. Widths are exact, with no truncation.

Optional Feature:
WB_RETIRE_COUNT_EN
- Defined: retire_cnt increments by 1 on every non-x0 commit. It is a 32-bit counter that wraps 0xFFFFFFFF -> 0 and is cleared by reset.
- Undefined: retire_cnt is constant 0 and no counter flops exist.

Decomposition:
- Shared package holds:
  - BIN_DIG, REG_NUM, REG_ADDR_W constants
  - wb_state_t enum {IDLE, HOLD}
  - wb_req_t struct {rd, value}, reused for skid entry and commit bus
- Sub-module gpr_file: register array, single write port, two bypassed read ports, x0 handling.
- The top level holds arbitration, FSM, skid buffer, wb_* outputs and the counter.

Test Plan:
- Reset, then rs1_addr=5 -> rs1_data=0, ex_ready=mem_ready=1, wb_valid=0.
- ex_valid, rd=3, value=0xDEADBEEF for one cycle -> next edge: wb_valid=1, wb_rd=3. Later rs1_addr=3 -> 0xDEADBEEF. During the commit cycle rs2_addr=3 -> 0xDEADBEEF via bypass.
- mem rd=4 value=0x11 and ex rd=7 value=0x22 together:
  - edge 1: reg4=0x11, state HOLD, both readies 0
  - edge 2: reg7=0x22, state IDLE
- mem rd=9 value=0xAA and ex rd=9 value=0xBB together -> reg9=0xBB after 2 edges; rs1_addr=9 reads 0xAA in the first cycle.
- ex rd=0 value=0xFFFFFFFF -> rs1_addr=0 reads 0, wb_valid=0, retire_cnt unchanged.
- With WB_RETIRE_COUNT_EN: 3 non-x0 commits -> retire_cnt=3. Assert RST_N=0 while in HOLD -> retire_cnt=0, state IDLE, and the skid entry's register is not written.
